// File: rtl/write_pkg.sv
// Shared types for the DDR5 PHY write manager: write FSM state encoding,
// burst-length codes and the watchdog counter width.
package write_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PREAMBLE   = 3'd1,
      WR_DATA    = 3'd2,
      WR_CRC     = 3'd3,
      INTERAMBLE = 3'd4,
      POSTAMBLE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      BL16 = 2'b00,
      BL8  = 2'b01
   } burst_len_t;

   localparam int unsigned WDT_CNT_W = 8;

endpackage

// File: rtl/write_fsm.sv
// Write-path control FSM of the DDR5 PHY write manager (Moore, registered outputs).
// Optional stall watchdog enabled by defining WRITE_FSM_WATCHDOG_EN.
module write_fsm
   import write_pkg::*;
#(
   parameter int unsigned BURST_CNT_W = 8
`ifdef WRITE_FSM_WATCHDOG_EN
   ,
   parameter int unsigned WDT_CYCLES  = 64
`endif
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_wr_en,
   input  logic                   i_preamble_done,
   input  logic                   i_wrdata_done,
   input  logic                   i_wrmask_done,
   input  logic                   i_wrdata_crc_done,
   input  logic                   i_interamble_done,
   input  logic                   i_postamble_done,
   input  logic                   i_interamble,
   input  logic                   i_crc_generate,
   output logic                   o_data_state,
   output logic                   o_post,
   output logic                   o_interamble_valid,
   output logic                   o_dqs_oe,
   output logic                   o_dq_oe,
   output logic                   o_crc_insert,
   output logic [BURST_CNT_W-1:0] o_burst_cnt,
   output logic [2:0]             o_state
`ifdef WRITE_FSM_WATCHDOG_EN
   ,
   output logic                   o_wdt_err
`endif
);

   state_t                 state;
   state_t                 state_nxt;
   logic [BURST_CNT_W-1:0] cnt_nxt;
   logic                   taken;
   logic                   eob;
`ifdef WRITE_FSM_WATCHDOG_EN
   logic [WDT_CNT_W-1:0]   wdt_cnt;
   logic [WDT_CNT_W-1:0]   wdt_nxt;
   logic                   wdt_fire;
`endif

   // Next state and burst count; only the current state's own done flag is honoured.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = o_burst_cnt;
      taken     = 1'b0;
      eob       = 1'b0;
      case (state)
         IDLE:       if (i_wr_en) begin state_nxt = PREAMBLE; taken = 1'b1; end
         PREAMBLE:   if (i_preamble_done) begin state_nxt = WR_DATA; taken = 1'b1; end
         WR_DATA: begin
            if (i_crc_generate) begin
               if (i_wrdata_done) begin state_nxt = WR_CRC; taken = 1'b1; end
            end else if (i_wrmask_done) begin
               eob = 1'b1;
            end
         end
         WR_CRC:     if (i_wrdata_crc_done) eob = 1'b1;
         INTERAMBLE: if (i_interamble_done) begin state_nxt = WR_DATA; taken = 1'b1; end
         POSTAMBLE: begin
            if (i_postamble_done) begin
               state_nxt = i_wr_en ? PREAMBLE : IDLE;
               taken     = 1'b1;
            end
         end
         default: begin state_nxt = IDLE; taken = 1'b1; end
      endcase
      // End of burst: seamless continuation takes priority over interamble.
      if (eob) begin
         taken = 1'b1;
         if (i_wr_en)          state_nxt = WR_DATA;
         else if (i_interamble) state_nxt = INTERAMBLE;
         else                   state_nxt = POSTAMBLE;
         if (o_burst_cnt != '1) cnt_nxt = o_burst_cnt + BURST_CNT_W'(1);
      end
`ifdef WRITE_FSM_WATCHDOG_EN
      wdt_nxt  = (state == IDLE || taken) ? '0 : wdt_cnt + WDT_CNT_W'(1);
      wdt_fire = (state != IDLE) && (wdt_cnt == WDT_CNT_W'(WDT_CYCLES - 1));
      if (wdt_fire) begin
         state_nxt = IDLE;
         wdt_nxt   = '0;
      end
`endif
      if (state_nxt == IDLE) cnt_nxt = '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state              <= IDLE;
         o_burst_cnt        <= '0;
         o_data_state       <= 1'b0;
         o_post             <= 1'b0;
         o_interamble_valid <= 1'b0;
         o_dqs_oe           <= 1'b0;
         o_dq_oe            <= 1'b0;
         o_crc_insert       <= 1'b0;
         o_state            <= 3'd0;
`ifdef WRITE_FSM_WATCHDOG_EN
         wdt_cnt            <= '0;
         o_wdt_err          <= 1'b0;
`endif
      end else begin
         state              <= state_nxt;
         o_burst_cnt        <= cnt_nxt;
         o_data_state       <= (state_nxt == WR_DATA) || (state_nxt == WR_CRC);
         o_post             <= (state_nxt == PREAMBLE) || (state_nxt == POSTAMBLE);
         o_interamble_valid <= (state_nxt == INTERAMBLE);
         o_dqs_oe           <= (state_nxt != IDLE);
         o_dq_oe            <= (state_nxt == WR_DATA) || (state_nxt == WR_CRC);
         o_crc_insert       <= (state_nxt == WR_CRC);
         o_state            <= 3'(state_nxt);
`ifdef WRITE_FSM_WATCHDOG_EN
         wdt_cnt            <= wdt_nxt;
         o_wdt_err          <= wdt_fire;
`endif
      end
   end

endmodule

// File: doc/write_fsm.md
Name: write_fsm

Overview:
- Write-path control state machine of the DDR5 PHY write manager.
- Consumes the done/decision flags produced by the write counter stage and drives back its state qualifiers (data state, pre/postamble state, interamble valid).
- Also drives DQ/DQS output enables and the CRC-insert strobe used by the DQ serializer.
- Sits directly between the memory-controller write-enable input and the write counter stage.

Parameters:
- BURST_CNT_W, 8, width of the seamless-burst counter.
- WDT_CYCLES, 64, watchdog limit: cycles spent in any non-IDLE state without an exit flag (optional feature only).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous, active-high reset.
- i_wr_en  input  1  write enable from memory controller.
- i_preamble_done  input  1  preamble finished.
- i_wrdata_done  input  1  data burst finished, PHY-CRC case.
- i_wrmask_done  input  1  data burst finished, no-CRC/mask case.
- i_wrdata_crc_done  input  1  CRC beats finished.
- i_interamble_done  input  1  interamble finished.
- i_postamble_done  input  1  postamble finished.
- i_interamble  input  1  next gap requires interamble instead of postamble+preamble.
- i_crc_generate  input  1  PHY generates and sends CRC.
- o_data_state  output  1  state is WR_DATA or WR_CRC.
- o_post  output  1  state is PREAMBLE or POSTAMBLE.
- o_interamble_valid  output  1  state is INTERAMBLE.
- o_dqs_oe  output  1  DQS driver enable (state != IDLE).
- o_dq_oe  output  1  DQ driver enable (equals o_data_state).
- o_crc_insert  output  1  state is WR_CRC.
- o_burst_cnt  output  BURST_CNT_W  bursts completed since leaving IDLE; saturating.
- o_state  output  3  encoded current state, debug only.

Behaviour:
- States and encodings: IDLE=0, PREAMBLE=1, WR_DATA=2, WR_CRC=3, INTERAMBLE=4, POSTAMBLE=5. Codes 6 and 7 are illegal and return to IDLE on the next edge.
- Reset: i_rst=1 at any edge forces IDLE, o_burst_cnt=0, and all other outputs 0. This applies mid-operation: there is no drain.
- All outputs are decoded from the registered state (Moore). They change on the same edge as the state register.
- Each done flag is honoured only in its own state; in any other state it is ignored.
- IDLE: i_wr_en=1 -> PREAMBLE. Otherwise remain in IDLE.
- PREAMBLE: i_preamble_done -> WR_DATA.
- WR_DATA:
  - i_crc_generate=1: i_wrdata_done -> WR_CRC.
  - i_crc_generate=0: i_wrmask_done -> end-of-burst (EOB) decision.
- WR_CRC: i_wrdata_crc_done -> EOB decision.
- EOB decision, evaluated on the same edge:
  - i_wr_en=1 -> WR_DATA (seamless).
  - else i_interamble=1 -> INTERAMBLE.
  - else -> POSTAMBLE.
- EOB increments o_burst_cnt by 1, saturating at all-ones.
- INTERAMBLE: i_interamble_done -> WR_DATA.
- POSTAMBLE:
  - i_postamble_done with i_wr_en=1 -> PREAMBLE; o_burst_cnt is kept.
  - i_postamble_done with i_wr_en=0 -> IDLE; o_burst_cnt is cleared on entering IDLE.
- Simultaneous flags: only the flag belonging to the current state is acted on. i_wr_en has no effect outside IDLE, EOB and POSTAMBLE exit.
- i_crc_generate and i_interamble are sampled only at the transition edge. Changing them mid-state has no effect until the next decision point.

Optional Feature:
- Macro: WRITE_FSM_WATCHDOG_EN.
- Defined:
  - Adds an 8-bit counter, cleared on every state change and in IDLE, incrementing each cycle otherwise.
  - When the counter reaches WDT_CYCLES-1, the FSM forces IDLE on the next edge and pulses o_wdt_err (extra 1-bit output port) for exactly one cycle.
  - o_burst_cnt is cleared.
- Not defined: no counter, no o_wdt_err port, and the FSM waits indefinitely for exit flags.

Decomposition:
- Package write_pkg holds:
  - the state enum typedef (3-bit, six states);
  - the burst-length encodings BL16=2'b00 and BL8=2'b01;
  - localparam WDT_CNT_W=8.
- No sub-module: the FSM, burst counter and watchdog are one always_ff block plus an output decode.

Test Plan:
- Single no-CRC write: i_wr_en pulse in IDLE, preamble_done 3 cycles later, wrmask_done after 4 more, wr_en=0, interamble=0, postamble_done 2 cycles later -> state sequence 0,1,2,5,0; o_dq_oe high exactly 4 cycles; o_burst_cnt=1 then 0 in IDLE.
- PHY CRC write: i_crc_generate=1, wrdata_done then wrdata_crc_done after 2 cycles -> WR_CRC lasts 2 cycles with o_crc_insert=1, then POSTAMBLE.
- Seamless pair: i_wr_en=1 at first EOB -> WR_DATA retained with no PREAMBLE; o_burst_cnt=2 at the second EOB.
- Interamble: i_interamble=1, wr_en=0 at EOB -> INTERAMBLE with o_interamble_valid=1; interamble_done -> WR_DATA; stray preamble_done during INTERAMBLE is ignored.
- Reset mid-burst: i_rst=1 for 1 cycle in WR_DATA -> next edge all outputs 0 and state IDLE; i_wr_en held 1 afterward -> PREAMBLE one cycle after reset deasserts.
- Watchdog (macro defined, WDT_CYCLES=64): hold PREAMBLE with no done for 64 cycles -> IDLE plus a single-cycle o_wdt_err; with macro undefined, state stays PREAMBLE.
